rv_mem_arbiter: RTL and testbench
=================================

Name: rv_mem_arbiter

Overview:
- Round-robin arbiter sharing the single DRAM/memory-controller data port between NCORE SMP cores in the RV cluster.
- Each core issues one outstanding access (read or write) with a level request. The arbiter picks a winner, registers its command, and drives it to the memory port using a ready/ack handshake. It broadcasts read data and pulses a per-core done.
- Sits between the per-core data-port outputs (addr/wdata/ctrl/we) and the memory controller, replacing the direct single-core connection.

Parameters:
- NCORE, 2, number of requesting cores (2..8).
- ADDR_W, 32, address width.
- WDATA_W, 32, write-data width.
- RDATA_W, 128, read-data line width.
- TIMEOUT_CYC, 1024, watchdog limit in cycles (used only with the optional feature).

Ports:
- CLK, in, 1, clock.
- RST_X, in, 1, reset.
- w_req, in, NCORE, per-core request level; held until that core's done.
- w_we, in, NCORE, per-core write enable.
- w_addr, in, NCORE*ADDR_W, per-core address; core i at bits [i*ADDR_W +: ADDR_W].
- w_wdata, in, NCORE*WDATA_W, per-core write data.
- w_ctrl, in, NCORE*3, per-core access size/type (same encoding as the core data_ctrl).
- w_gnt, out, NCORE, one-hot owner of the port; 0 when idle.
- w_done, out, NCORE, one-cycle completion pulse to the owner.
- w_rdata, out, RDATA_W, registered read data, broadcast to all cores.
- w_err, out, 1, completion-by-timeout flag, valid with w_done.
- w_mem_req, out, 1, command valid to the memory controller.
- w_mem_we, out, 1, registered write enable.
- w_mem_addr, out, ADDR_W, registered address.
- w_mem_wdata, out, WDATA_W, registered write data.
- w_mem_ctrl, out, 3, registered ctrl.
- w_mem_busy, in, 1, controller cannot accept; a command is accepted in a cycle with w_mem_req=1 and w_mem_busy=0.
- w_mem_ack, in, 1, one-cycle completion pulse; w_mem_rdata is valid in the same cycle.
- w_mem_rdata, in, RDATA_W, read data from the controller.

Behaviour:
- Clock CLK. Reset RST_X, asynchronous, active-low.
- Reset values: all outputs 0; state=IDLE; round-robin pointer ptr=0; watchdog count=0.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - If w_req!=0, select the first requester at or after ptr, scanning upward modulo NCORE.
  - Register the winner index, w_we/w_addr/w_wdata/w_ctrl into w_mem_*, set w_gnt one-hot, go to ISSUE.
  - If w_req==0, stay in IDLE.
- ISSUE: w_mem_req=1. If w_mem_busy=0, the command is accepted this cycle; go to WAIT. Otherwise hold all w_mem_* stable.
- WAIT: w_mem_req=0. On w_mem_ack, register w_mem_rdata into w_rdata and go to DONE.
- DONE:
  - w_done[winner]=1 for exactly one cycle; w_gnt is still asserted.
  - Set ptr = (winner+1) mod NCORE; go to IDLE.
  - w_gnt clears on entry to IDLE.
- Latency: request sampled in IDLE at cycle 0 → w_mem_req at cycle 1 → with zero busy and ack at cycle 2, w_done at cycle 3. Minimum 4 cycles per transaction; no back-to-back overlap.
- Requester rules:
  - The core drops w_req in the cycle after w_done unless it is issuing a new access. If w_req is still high in IDLE, that is a new request.
  - The command is captured at grant; later changes to a core's inputs are ignored.
  - w_req dropped mid-transaction: the transaction still completes and done still pulses.
- w_mem_ack outside WAIT is ignored. w_rdata holds its last value until the next ack capture, including after writes.
- Fairness: a requester waits for at most NCORE-1 other transactions.
- Reset mid-operation: immediate return to IDLE and all outputs 0. The memory controller is reset by the same RST_X.

Optional Feature:
- Macro RVARB_TIMEOUT_EN.
- Defined:
  - Counter clears on entry to ISSUE and increments in ISSUE/WAIT.
  - On reaching TIMEOUT_CYC without ack, go to DONE with w_err=1 and w_rdata unchanged.
  - A late ack arriving in IDLE is ignored.
- Undefined: no counter; w_err tied 0; ISSUE/WAIT wait indefinitely.

Decomposition:
- Shared package rv_cluster_pkg holds:
  - state encodings ST_IDLE=0, ST_ISSUE=1, ST_WAIT=2, ST_DONE=3;
  - the data_ctrl size encodings;
  - default widths.
- One sub-module rv_rr_pick: combinational round-robin selector (req, ptr → one-hot grant plus index). The FSM and registers stay in the top module.

Test Plan:
- Single read, NCORE=2: core0 req, addr=0x80001000, we=0; mem_busy=0; ack with rdata=128'hDEADBEEF at cycle 2 → w_mem_req at cycle 1, w_done[0] at cycle 3, w_rdata=0xDEADBEEF, w_gnt=01 for cycles 1-3.
- Contention: core0 and core1 req together from reset, both re-request immediately → grant order 0,1,0,1; w_gnt never 11.
- Busy stall: mem_busy=1 for 5 cycles in ISSUE, core1 write addr=0x10, wdata=0x12345678, ctrl=3'b010 → w_mem_* stable and w_mem_req held 6 cycles; accepted in the busy=0 cycle.
- Req dropped: core1 drops w_req in WAIT → w_done[1] still pulses after ack; ptr advances to 0.
- Reset mid-WAIT: RST_X low asynchronously → w_gnt, w_mem_req, w_done all 0 immediately; after release, the next request starts from core0.
- With RVARB_TIMEOUT_EN and TIMEOUT_CYC=16, no ack → w_done and w_err=1 exactly 16 cycles after ISSUE entry; without the macro, the FSM stays in WAIT and w_err=0.

Source files
------------

// File: rtl/rv_cluster_pkg.sv
// rtl/rv_cluster_pkg.sv - shared RV cluster types: arbiter states, data_ctrl encodings, default widths
package rv_cluster_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } arb_state_t;

    // data_ctrl: size in [1:0], zero-extend flag in [2]
    localparam logic [2:0] DCTRL_BYTE  = 3'b000;
    localparam logic [2:0] DCTRL_HALF  = 3'b001;
    localparam logic [2:0] DCTRL_WORD  = 3'b010;
    localparam logic [2:0] DCTRL_BYTEU = 3'b100;
    localparam logic [2:0] DCTRL_HALFU = 3'b101;

    localparam int DEF_NCORE       = 2;
    localparam int DEF_ADDR_W      = 32;
    localparam int DEF_WDATA_W     = 32;
    localparam int DEF_RDATA_W     = 128;
    localparam int DEF_TIMEOUT_CYC = 1024;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rv_rr_pick.sv
// rtl/rv_rr_pick.sv - combinational round-robin selector: first requester at or after ptr
module rv_rr_pick #(
    parameter int NCORE = 2,
    parameter int IDX_W = 1
) (
    input  logic [NCORE-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [NCORE-1:0] gnt,
    output logic [IDX_W-1:0] idx,
    output logic             vld
);

    always_comb begin
        gnt = '0;
        idx = '0;
        vld = 1'b0;
        for (int i = 0; i < NCORE; i++) begin
            if (!vld && req[(int'(ptr) + i) % NCORE]) begin
                vld                          = 1'b1;
                gnt[(int'(ptr) + i) % NCORE] = 1'b1;
                idx                          = IDX_W'((int'(ptr) + i) % NCORE);
            end
        end
    end

endmodule

// File: rtl/rv_mem_arbiter.sv
// rtl/rv_mem_arbiter.sv - round-robin arbiter for the shared memory port; watchdog under RVARB_TIMEOUT_EN
module rv_mem_arbiter
    import rv_cluster_pkg::*;
#(
    parameter int          NCORE       = DEF_NCORE,
    parameter int          ADDR_W      = DEF_ADDR_W,
    parameter int          WDATA_W     = DEF_WDATA_W,
    parameter int          RDATA_W     = DEF_RDATA_W,
    parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic                       CLK,
    input  logic                       RST_X,
    input  logic [NCORE-1:0]           w_req,
    input  logic [NCORE-1:0]           w_we,
    input  logic [NCORE*ADDR_W-1:0]    w_addr,
    input  logic [NCORE*WDATA_W-1:0]   w_wdata,
    input  logic [NCORE*3-1:0]         w_ctrl,
    output logic [NCORE-1:0]           w_gnt,
    output logic [NCORE-1:0]           w_done,
    output logic [RDATA_W-1:0]         w_rdata,
    output logic                       w_err,
    output logic                       w_mem_req,
    output logic                       w_mem_we,
    output logic [ADDR_W-1:0]          w_mem_addr,
    output logic [WDATA_W-1:0]         w_mem_wdata,
    output logic [2:0]                 w_mem_ctrl,
    input  logic                       w_mem_busy,
    input  logic                       w_mem_ack,
    input  logic [RDATA_W-1:0]         w_mem_rdata
);

    localparam int IDX_W = idx_w(NCORE);

    arb_state_t       state;
    arb_state_t       state_nxt;
    logic             timeout_done;
    logic             wd_hit;
    logic [NCORE-1:0] pick_gnt;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_vld;
    logic [IDX_W-1:0] owner;
    logic [IDX_W-1:0] ptr;

    rv_rr_pick #(
        .NCORE (NCORE),
        .IDX_W (IDX_W)
    ) u_pick (
        .req (w_req),
        .ptr (ptr),
        .gnt (pick_gnt),
        .idx (pick_idx),
        .vld (pick_vld)
    );

    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // An ack always wins over a watchdog expiry in the same cycle.
    always_comb begin
        state_nxt    = state;
        timeout_done = 1'b0;
        case (state)
            ST_IDLE: begin
                if (pick_vld) state_nxt = ST_ISSUE;
            end
            ST_ISSUE: begin
                if (!w_mem_busy) begin
                    state_nxt = ST_WAIT;
                end else if (wd_hit) begin
                    state_nxt    = ST_DONE;
                    timeout_done = 1'b1;
                end
            end
            ST_WAIT: begin
                if (w_mem_ack) begin
                    state_nxt = ST_DONE;
                end else if (wd_hit) begin
                    state_nxt    = ST_DONE;
                    timeout_done = 1'b1;
                end
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            owner       <= '0;
            ptr         <= '0;
            w_gnt       <= '0;
            w_done      <= '0;
            w_rdata     <= '0;
            w_err       <= 1'b0;
            w_mem_req   <= 1'b0;
            w_mem_we    <= 1'b0;
            w_mem_addr  <= '0;
            w_mem_wdata <= '0;
            w_mem_ctrl  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick_vld) begin
                        owner       <= pick_idx;
                        w_gnt       <= pick_gnt;
                        w_mem_req   <= 1'b1;
                        w_mem_we    <= w_we[pick_idx];
                        w_mem_addr  <= w_addr[int'(pick_idx)*ADDR_W +: ADDR_W];
                        w_mem_wdata <= w_wdata[int'(pick_idx)*WDATA_W +: WDATA_W];
                        w_mem_ctrl  <= w_ctrl[int'(pick_idx)*3 +: 3];
                    end
                end
                ST_ISSUE: begin
                    if (timeout_done) begin
                        w_mem_req <= 1'b0;
                        w_done    <= w_gnt;
                        w_err     <= 1'b1;
                    end else if (!w_mem_busy) begin
                        w_mem_req <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (w_mem_ack) begin
                        w_rdata <= w_mem_rdata;
                        w_done  <= w_gnt;
                    end else if (timeout_done) begin
                        w_done <= w_gnt;
                        w_err  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    w_done <= '0;
                    w_err  <= 1'b0;
                    w_gnt  <= '0;
                    ptr    <= (int'(owner) == NCORE - 1) ? '0 : owner + 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef RVARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] wd_cnt;

    // Count is zero on the first ISSUE cycle, so expiry lands DONE exactly TIMEOUT_CYC cycles later.
    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            wd_cnt <= '0;
        end else if (state == ST_IDLE) begin
            wd_cnt <= '0;
        end else if ((state == ST_ISSUE || state == ST_WAIT) && !wd_hit) begin
            wd_cnt <= wd_cnt + 1'b1;
        end
    end

    assign wd_hit = (wd_cnt >= CNT_W'(TIMEOUT_CYC - 1));
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = ^TIMEOUT_CYC;
    assign wd_hit             = 1'b0;
`endif

endmodule

// File: tb/tb_rv_mem_arbiter.sv
// tb/tb_rv_mem_arbiter.sv - randomized self-checking bench for rv_mem_arbiter against a transaction-level model
module tb_rv_mem_arbiter;

    localparam int NCORE       = 3;
    localparam int ADDR_W      = 32;
    localparam int WDATA_W     = 32;
    localparam int RDATA_W     = 128;
    localparam int TIMEOUT_CYC = 16;

    logic                     CLK = 1'b0;
    logic                     RST_X;
    logic [NCORE-1:0]         w_req;
    logic [NCORE-1:0]         w_we;
    logic [NCORE*ADDR_W-1:0]  w_addr;
    logic [NCORE*WDATA_W-1:0] w_wdata;
    logic [NCORE*3-1:0]       w_ctrl;
    logic [NCORE-1:0]         w_gnt;
    logic [NCORE-1:0]         w_done;
    logic [RDATA_W-1:0]       w_rdata;
    logic                     w_err;
    logic                     w_mem_req;
    logic                     w_mem_we;
    logic [ADDR_W-1:0]        w_mem_addr;
    logic [WDATA_W-1:0]       w_mem_wdata;
    logic [2:0]               w_mem_ctrl;
    logic                     w_mem_busy;
    logic                     w_mem_ack;
    logic [RDATA_W-1:0]       w_mem_rdata;

    int               errors = 0;
    int               checks = 0;
    int               ptr_m;
    logic [127:0]     rdata_m;
    logic [NCORE-1:0] gnt_q[$];

    always #5 CLK = ~CLK;

    rv_mem_arbiter #(
        .NCORE       (NCORE),
        .ADDR_W      (ADDR_W),
        .WDATA_W     (WDATA_W),
        .RDATA_W     (RDATA_W),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .CLK         (CLK),
        .RST_X       (RST_X),
        .w_req       (w_req),
        .w_we        (w_we),
        .w_addr      (w_addr),
        .w_wdata     (w_wdata),
        .w_ctrl      (w_ctrl),
        .w_gnt       (w_gnt),
        .w_done      (w_done),
        .w_rdata     (w_rdata),
        .w_err       (w_err),
        .w_mem_req   (w_mem_req),
        .w_mem_we    (w_mem_we),
        .w_mem_addr  (w_mem_addr),
        .w_mem_wdata (w_mem_wdata),
        .w_mem_ctrl  (w_mem_ctrl),
        .w_mem_busy  (w_mem_busy),
        .w_mem_ack   (w_mem_ack),
        .w_mem_rdata (w_mem_rdata)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic set_cmd(input int c, input logic we, input logic [31:0] a,
                           input logic [31:0] d, input logic [2:0] ct);
        w_we[c]                      = we;
        w_addr[c*ADDR_W +: ADDR_W]   = a;
        w_wdata[c*WDATA_W +: WDATA_W] = d;
        w_ctrl[c*3 +: 3]             = ct;
    endtask

    task automatic rand_cmd(input int c);
        set_cmd(c, 1'($urandom), $urandom, $urandom, 3'($urandom));
    endtask

    task automatic do_reset();
        RST_X       = 1'b0;
        w_req       = '0;
        w_mem_busy  = 1'b0;
        w_mem_ack   = 1'b0;
        w_mem_rdata = '0;
        repeat (2) step();
        RST_X   = 1'b1;
        ptr_m   = 0;
        rdata_m = '0;
        step();
    endtask

    // Called in an IDLE cycle with w_req nonzero; returns after the following IDLE cycle.
    task automatic run_txn(input int busy_n, input int ack_dly, input logic [127:0] rd,
                           input bit drop, input bit rereq, output int win);
        logic             exp_we;
        logic [31:0]      exp_a;
        logic [31:0]      exp_d;
        logic [2:0]       exp_c;
        logic [NCORE-1:0] oh;
        win = -1;
        for (int k = 0; k < NCORE; k++)
            if (win < 0 && w_req[(ptr_m + k) % NCORE]) win = (ptr_m + k) % NCORE;
        if (win < 0) begin
            errors++;
            $display("FAIL run_txn: called with no request pending");
            return;
        end
        oh      = '0;
        oh[win] = 1'b1;
        exp_we  = w_we[win];
        exp_a   = w_addr[win*ADDR_W +: ADDR_W];
        exp_d   = w_wdata[win*WDATA_W +: WDATA_W];
        exp_c   = w_ctrl[win*3 +: 3];
        step();
        gnt_q.push_back(w_gnt);
        check("gnt_issue", w_gnt, oh);
        check("mem_req_issue", w_mem_req, 1'b1);
        check("mem_we", w_mem_we, exp_we);
        check("mem_addr", w_mem_addr, exp_a);
        check("mem_wdata", w_mem_wdata, exp_d);
        check("mem_ctrl", w_mem_ctrl, exp_c);
        check("done_issue", w_done, '0);
        rand_cmd(win);
        for (int b = 0; b < busy_n; b++) begin
            w_mem_busy  = 1'b1;
            w_mem_ack   = 1'($urandom);
            w_mem_rdata = rand128();
            step();
            check("mem_req_busy", w_mem_req, 1'b1);
            check("addr_busy", w_mem_addr, exp_a);
            check("wdata_busy", w_mem_wdata, exp_d);
            check("ctrl_busy", w_mem_ctrl, exp_c);
        end
        w_mem_busy  = 1'b0;
        w_mem_ack   = 1'($urandom);
        w_mem_rdata = rand128();
        step();
        w_mem_ack = 1'b0;
        check("mem_req_wait", w_mem_req, 1'b0);
        check("gnt_wait", w_gnt, oh);
        check("done_wait", w_done, '0);
        check("rdata_hold", w_rdata, rdata_m);
        if (drop) w_req[win] = 1'b0;
        for (int d = 0; d < ack_dly; d++) begin
            step();
            check("done_early", w_done, '0);
            check("gnt_hold", w_gnt, oh);
        end
        w_mem_ack   = 1'b1;
        w_mem_rdata = rd;
        step();
        w_mem_ack   = 1'b0;
        w_mem_rdata = rand128();
        rdata_m     = rd;
        ptr_m       = (win + 1) % NCORE;
        check("done", w_done, oh);
        check("gnt_done", w_gnt, oh);
        check("rdata", w_rdata, rd);
        check("err_done", w_err, 1'b0);
        w_req[win] = rereq;
        if (rereq) rand_cmd(win);
        step();
        check("gnt_idle", w_gnt, '0);
        check("done_idle", w_done, '0);
        check("rdata_idle", w_rdata, rdata_m);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int win;
        logic [NCORE-1:0] exp_order [4];
        RST_X       = 1'b0;
        w_req       = '0;
        w_we        = '0;
        w_addr      = '0;
        w_wdata     = '0;
        w_ctrl      = '0;
        w_mem_busy  = 1'b0;
        w_mem_ack   = 1'b0;
        w_mem_rdata = '0;
        repeat (2) step();
        check("rst_gnt", w_gnt, '0);
        check("rst_done", w_done, '0);
        check("rst_rdata", w_rdata, '0);
        check("rst_err", w_err, 1'b0);
        check("rst_mem_req", w_mem_req, 1'b0);
        check("rst_mem_addr", w_mem_addr, '0);
        check("rst_mem_wdata", w_mem_wdata, '0);
        check("rst_mem_we_ctrl", {w_mem_we, w_mem_ctrl}, '0);
        RST_X   = 1'b1;
        ptr_m   = 0;
        rdata_m = '0;
        step();

        // single read, minimum latency
        set_cmd(0, 1'b0, 32'h8000_1000, 32'h0, 3'b010);
        w_req = 3'b001;
        run_txn(0, 0, 128'hDEADBEEF, 1'b0, 1'b0, win);

        // contention from reset: 0,1,0,1
        do_reset();
        gnt_q.delete();
        rand_cmd(0);
        rand_cmd(1);
        w_req = 3'b011;
        for (int i = 0; i < 4; i++) run_txn(0, $urandom_range(0, 1), rand128(), 1'b0, i < 2, win);
        exp_order = '{3'b001, 3'b010, 3'b001, 3'b010};
        for (int i = 0; i < 4; i++) check("contention_order", gnt_q[i], exp_order[i]);

        // busy stall on a write
        set_cmd(1, 1'b1, 32'h10, 32'h1234_5678, 3'b010);
        w_req = 3'b010;
        run_txn(5, 1, rand128(), 1'b0, 1'b0, win);

        // request dropped while waiting, then pointer advance
        rand_cmd(1);
        w_req = 3'b010;
        run_txn(0, 2, rand128(), 1'b1, 1'b0, win);
        rand_cmd(0);
        rand_cmd(2);
        w_req = 3'b101;
        run_txn(0, 0, rand128(), 1'b0, 1'b0, win);
        run_txn(1, 0, rand128(), 1'b0, 1'b0, win);

        // reset mid-WAIT with ptr parked on core1
        rand_cmd(0);
        w_req = 3'b001;
        run_txn(0, 0, rand128(), 1'b0, 1'b0, win);
        rand_cmd(1);
        w_req = 3'b010;
        step();
        step();
        check("pre_rst_gnt", w_gnt, 3'b010);
        #2;
        RST_X = 1'b0;
        #1;
        check("async_rst_gnt", w_gnt, '0);
        check("async_rst_mem_req", w_mem_req, 1'b0);
        check("async_rst_done", w_done, '0);
        check("async_rst_addr", w_mem_addr, '0);
        rand_cmd(0);
        rand_cmd(1);
        w_req = 3'b011;
        step();
        RST_X   = 1'b1;
        ptr_m   = 0;
        rdata_m = '0;
        run_txn(0, 0, rand128(), 1'b0, 1'b0, win);
        run_txn(0, 1, rand128(), 1'b0, 1'b0, win);

        // no ack from the controller
        rand_cmd(2);
        w_req = 3'b100;
        step();
        check("noack_gnt", w_gnt, 3'b100);
        w_mem_busy = 1'b0;
        step();
`ifdef RVARB_TIMEOUT_EN
        for (int k = 3; k <= TIMEOUT_CYC; k++) begin
            step();
            check("to_early_done", w_done, '0);
        end
        step();
        check("to_done", w_done, 3'b100);
        check("to_err", w_err, 1'b1);
        check("to_rdata", w_rdata, rdata_m);
        w_req = '0;
        step();
        check("to_err_clear", w_err, 1'b0);
        check("to_gnt_clear", w_gnt, '0);
        w_mem_ack   = 1'b1;
        w_mem_rdata = rand128();
        step();
        w_mem_ack = 1'b0;
        check("late_ack_rdata", w_rdata, rdata_m);
        check("late_ack_done", w_done, '0);
        ptr_m = 0;
`else
        for (int k = 0; k < 20; k++) begin
            step();
            check("noack_done", w_done, '0);
            check("noack_err", w_err, 1'b0);
            check("noack_gnt_hold", w_gnt, 3'b100);
        end
        w_mem_ack   = 1'b1;
        w_mem_rdata = rand128();
        rdata_m     = w_mem_rdata;
        step();
        w_mem_ack = 1'b0;
        check("noack_late_done", w_done, 3'b100);
        check("noack_late_rdata", w_rdata, rdata_m);
        check("noack_late_err", w_err, 1'b0);
        w_req = '0;
        ptr_m = 0;
        step();
        check("noack_idle_gnt", w_gnt, '0);
`endif

        // randomized traffic
        for (int n = 0; n < 40; n++) begin
            if (w_req == '0) begin
                if ($urandom_range(0, 3) == 0) begin
                    w_mem_ack   = 1'($urandom);
                    w_mem_rdata = rand128();
                    step();
                    w_mem_ack = 1'b0;
                    check("idle_gnt", w_gnt, '0);
                    check("idle_rdata", w_rdata, rdata_m);
                end
                for (int c = 0; c < NCORE; c++) begin
                    if ($urandom_range(0, 1) == 1) begin
                        rand_cmd(c);
                        w_req[c] = 1'b1;
                    end
                end
                if (w_req == '0) begin
                    int c0;
                    c0 = $urandom_range(0, NCORE - 1);
                    rand_cmd(c0);
                    w_req[c0] = 1'b1;
                end
            end
            run_txn($urandom_range(0, 3), $urandom_range(0, 3), rand128(),
                    $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1, win);
            for (int c = 0; c < NCORE; c++) begin
                if (!w_req[c] && $urandom_range(0, 2) == 0) begin
                    rand_cmd(c);
                    w_req[c] = 1'b1;
                end
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
